// File: rtl/calc_sequencer_pkg.sv
// calc_sequencer_pkg: shared FSM encoding and default datapath width
package calc_sequencer_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIX  = 2'd2,
    SHOW = 2'd3
  } state_t;
endpackage

// File: rtl/calc_sequencer_btn_pulse.sv
// btn_pulse: synchronize, debounce and one-shot a raw button on its accepted press
module btn_pulse #(
  parameter int DEBOUNCE_CNT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  logic [1:0] sync;
  logic deb;
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = (sync[1] != deb) && (cnt == CW'(DEBOUNCE_CNT - 1));
  // synchronizer, stability counter, debounced level and rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      deb   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      cnt   <= (sync[1] == deb || hit) ? '0 : cnt + 1'b1;
      deb   <= hit ? ~deb : deb;
      pulse <= hit & ~deb;
    end
  end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: operand capture and shared-adder scheduling for the add/sub calculator
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int DEBOUNCE_CNT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             op_sub,
  input  logic             btn_a,
  input  logic             btn_b,
  input  logic             btn_go,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);
  state_t state, next;
  logic pulse_a, pulse_b, pulse_go;
  logic a_ok, b_ok, sub;
  logic idle_show, load, start, borrow;

  btn_pulse #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_btn_a  (.clk(clk), .rst(rst), .raw(btn_a),  .pulse(pulse_a));
  btn_pulse #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_btn_b  (.clk(clk), .rst(rst), .raw(btn_b),  .pulse(pulse_b));
  btn_pulse #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_btn_go (.clk(clk), .rst(rst), .raw(btn_go), .pulse(pulse_go));

  assign idle_show    = (state == IDLE) || (state == SHOW);
  assign load         = pulse_a | pulse_b;
  assign start        = idle_show & pulse_go & a_ok & b_ok & ~load;
  assign borrow       = sub & ~add_cout;
  assign result_valid = (state == SHOW);
  assign busy         = (state == EXEC) || (state == FIX);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // next state and adder operand steering; FIX swaps operands to get |A-B|
  always_comb begin
    next    = state;
    add_a   = reg_a;
    add_b   = reg_b;
    add_sub = op_sub;
    case (state)
      IDLE, SHOW: next = load ? IDLE : (start ? EXEC : state);
      EXEC: begin
        add_sub = sub;
        next    = borrow ? FIX : SHOW;
      end
      FIX: begin
        add_a   = reg_b;
        add_b   = reg_a;
        add_sub = 1'b1;
        next    = SHOW;
      end
      default: next = IDLE;
    endcase
  end

  // operand registers, latched op and result/flag capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a  <= '0;
      reg_b  <= '0;
      a_ok   <= 1'b0;
      b_ok   <= 1'b0;
      sub    <= 1'b0;
      result <= '0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (idle_show && pulse_a) begin
        reg_a <= sw;
        a_ok  <= 1'b1;
      end
      if (idle_show && pulse_b) begin
        reg_b <= sw;
        b_ok  <= 1'b1;
      end
      if (start) sub <= op_sub;
      if (state == SHOW && load) begin
        neg <= 1'b0;
        ovf <= 1'b0;
      end
      if (state == EXEC && !borrow) begin
        result <= add_s;
        neg    <= 1'b0;
        ovf    <= ~sub & add_cout;
      end
      if (state == FIX) begin
        result <= add_s;
        neg    <= 1'b1;
        ovf    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer with a behavioural adder
module tb_calc_sequencer;
  logic clk = 0, rst = 1;
  logic [7:0] sw = 0;
  logic op_sub = 0, btn_a = 0, btn_b = 0, btn_go = 0;
  logic [7:0] add_a, add_b, add_s, reg_a, reg_b, result;
  logic add_sub, add_cout, result_valid, neg, ovf, busy;
  int checks = 0, errors = 0, pa_cnt = 0;
  typedef struct {logic [7:0] r; logic n; logic o;} exp_t;
  exp_t q[$];
  logic prev_v = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)} + {8'd0, add_sub};

  calc_sequencer #(.WIDTH(8), .DEBOUNCE_CNT(4)) u_dut (
    .clk(clk), .rst(rst), .sw(sw), .op_sub(op_sub),
    .btn_a(btn_a), .btn_b(btn_b), .btn_go(btn_go),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .add_s(add_s), .add_cout(add_cout),
    .reg_a(reg_a), .reg_b(reg_b), .result(result),
    .result_valid(result_valid), .neg(neg), .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pop one expectation on every rising edge of result_valid
  always @(negedge clk) begin
    if (result_valid && !prev_v) begin
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.r);
        chk("neg", neg, e.n);
        chk("ovf", ovf, e.o);
      end
    end
    prev_v <= result_valid;
  end

  always @(negedge clk) if (u_dut.pulse_a) pa_cnt++;

  task automatic load(input bit which_b, input logic [7:0] v);
    sw = v;
    if (which_b) btn_b = 1; else btn_a = 1;
    repeat (8) @(negedge clk);
    btn_a = 0;
    btn_b = 0;
    repeat (8) @(negedge clk);
    if (which_b) chk("reg_b", reg_b, v); else chk("reg_a", reg_a, v);
  endtask

  task automatic do_go(input logic [7:0] r, input logic n, input logic o,
                       input bit fix, input logic [7:0] fa, input logic [7:0] fb);
    q.push_back('{r, n, o});
    btn_go = 1;
    repeat (6) @(negedge clk);
    chk("busy_pulse_cycle", busy, 0);
    @(negedge clk);
    chk("busy_exec", busy, 1);
    chk("valid_exec", result_valid, 0);
    if (fix) begin
      @(negedge clk);
      chk("busy_fix", busy, 1);
      chk("fix_add_a", add_a, fa);
      chk("fix_add_b", add_b, fb);
      chk("fix_add_sub", add_sub, 1);
    end
    @(negedge clk);
    chk("valid_show", result_valid, 1);
    chk("busy_show", busy, 0);
    btn_go = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic go_ignored();
    bit seen = 0;
    btn_go = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      seen |= busy | result_valid;
      if (i == 7) btn_go = 0;
    end
    chk("go_ignored", seen, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    // add
    load(0, 25); load(1, 17); op_sub = 0;
    do_go(42, 0, 0, 0, 0, 0);
    // add overflow, then non-negative subtract
    load(0, 200); load(1, 100);
    do_go(44, 0, 1, 0, 0, 0);
    load(0, 100); load(1, 30); op_sub = 1;
    do_go(70, 0, 0, 0, 0, 0);
    // negative subtract through FIX, then equal operands
    load(0, 30); load(1, 100);
    do_go(70, 1, 0, 1, 100, 30);
    load(0, 55); load(1, 55);
    do_go(0, 0, 0, 0, 0, 0);
    // go without B is ignored; load in SHOW drops valid
    rst = 1; @(negedge clk); rst = 0;
    load(0, 7);
    go_ignored();
    load(1, 3); op_sub = 0;
    do_go(10, 0, 0, 0, 0, 0);
    sw = 9; btn_b = 1;
    repeat (6) @(negedge clk);
    chk("valid_before_load", result_valid, 1);
    @(negedge clk);
    chk("valid_after_load", result_valid, 0);
    chk("neg_after_load", neg, 0);
    repeat (7) @(negedge clk);
    btn_b = 0;
    repeat (8) @(negedge clk);
    chk("reg_b_show", reg_b, 9);
    // short glitch is rejected
    sw = 99; btn_a = 1;
    repeat (2) @(negedge clk);
    btn_a = 0;
    repeat (10) @(negedge clk);
    chk("glitch_reg_a", reg_a, 7);
    // dropout during a long press yields exactly one load
    pa_cnt = 0; sw = 50;
    for (int i = 0; i < 12; i++) begin
      btn_a = (i != 2);
      @(negedge clk);
    end
    btn_a = 0;
    repeat (10) @(negedge clk);
    chk("dropout_pulses", pa_cnt, 1);
    chk("dropout_reg_a", reg_a, 50);
    // a button pulse landing in EXEC is dropped
    q.push_back('{8'd59, 1'b0, 1'b0});
    btn_go = 1;
    @(negedge clk);
    sw = 77; btn_b = 1;
    repeat (6) @(negedge clk);
    chk("busy_exec_drop", busy, 1);
    @(negedge clk);
    chk("valid_exec_drop", result_valid, 1);
    btn_go = 0;
    repeat (4) @(negedge clk);
    btn_b = 0;
    repeat (8) @(negedge clk);
    chk("reg_b_exec_drop", reg_b, 9);
    chk("valid_hold", result_valid, 1);
    // reset in FIX
    op_sub = 1;
    load(0, 10); load(1, 20);
    btn_go = 1;
    repeat (8) @(negedge clk);
    chk("in_fix", busy, 1);
    chk("in_fix_add_a", add_a, 20);
    rst = 1;
    #1;
    chk("fixrst_result", result, 0);
    chk("fixrst_valid", result_valid, 0);
    chk("fixrst_busy", busy, 0);
    chk("fixrst_neg", neg, 0);
    chk("fixrst_ovf", ovf, 0);
    chk("fixrst_reg_a", reg_a, 0);
    chk("fixrst_reg_b", reg_b, 0);
    @(negedge clk);
    rst = 0; btn_go = 0;
    repeat (8) @(negedge clk);
    go_ignored();
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control block for the two-operand add/subtract calculator datapath (operand registers, B inverter, ripple adder, BCD display path).
- Debounces the raw load and execute buttons and holds operands A and B.
- Schedules the single shared adder: one pass for add or non-negative subtract, a second swapped-operand pass when a subtract goes negative.
- Presents a registered, sign-magnitude result with valid, negative and overflow flags to the bin2bcd / seven-segment path.

Parameters:
- WIDTH, 8, operand and result width.
- DEBOUNCE_CNT, 100000, consecutive stable cycles required before a button change is accepted; use 4 in simulation.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- sw  in  WIDTH  operand switches
- op_sub  in  1  level: 0 = add, 1 = subtract; sampled on accepted go
- btn_a  in  1  raw button: load A from sw
- btn_b  in  1  raw button: load B from sw
- btn_go  in  1  raw button: execute
- add_a  out  WIDTH  shared adder operand A
- add_b  out  WIDTH  shared adder operand B (before inverter)
- add_sub  out  1  drives inverter inv and adder Cin
- add_s  in  WIDTH  adder sum (combinational, same cycle)
- add_cout  in  1  adder carry out
- reg_a  out  WIDTH  held operand A
- reg_b  out  WIDTH  held operand B
- result  out  WIDTH  magnitude of last result
- result_valid  out  1  result is current
- neg  out  1  result is negative (subtract only)
- ovf  out  1  unsigned add overflow
- busy  out  1  high in EXEC or FIX

Behaviour:
- Reset: all outputs, registers, flags (a_ok, b_ok, latched sub) and debounce state cleared to 0; FSM = IDLE. Reset is honoured mid-operation, including in FIX.
- Button path, per button:
  - 2-FF synchronizer, then debounce counter.
  - Counter clears whenever the synced input equals the debounced state.
  - Debounced state flips after DEBOUNCE_CNT consecutive differing cycles.
  - One-cycle pulse on each debounced rising edge; exactly one pulse per accepted press; no pulse on release.
- FSM states: IDLE, EXEC, FIX, SHOW.
- IDLE / SHOW:
  - pulse_a: reg_a <= sw, a_ok <= 1. pulse_b: reg_b <= sw, b_ok <= 1. Both in one cycle: both load.
  - Any load in SHOW -> IDLE and clears result_valid, neg and ovf.
  - pulse_go with a_ok & b_ok and no load pulse in that cycle -> EXEC; latch sub <= op_sub.
  - pulse_go otherwise is ignored: no state change.
  - pulse_go in SHOW re-executes with the current operands.
- EXEC (1 cycle): add_a = reg_a, add_b = reg_b, add_sub = sub. At cycle end:
  - add: result <= add_s, ovf <= add_cout, neg <= 0 -> SHOW.
  - sub with add_cout = 1 (A >= B): result <= add_s, neg <= 0, ovf <= 0 -> SHOW.
  - sub with add_cout = 0 (A < B): -> FIX.
- FIX (1 cycle): add_a = reg_b, add_b = reg_a, add_sub = 1. result <= add_s, neg <= 1, ovf <= 0 -> SHOW.
- SHOW: result_valid = 1; holds until a load pulse or reset.
- Button pulses arriving in EXEC or FIX are dropped.
- Outside EXEC/FIX: add_a = reg_a, add_b = reg_b, add_sub = op_sub (live preview).
- Latency from pulse_go cycle to result_valid high: 2 cycles without FIX, 3 cycles with FIX.
- Arithmetic is modulo 2^WIDTH. A == B subtract gives result 0 with neg 0.

Decomposition:
- Shared package/include: FSM state encodings (IDLE = 0, EXEC = 1, FIX = 2, SHOW = 3) and default WIDTH.
- One sub-module, btn_pulse (synchronizer + debounce + rising-edge one-shot, parameter DEBOUNCE_CNT), instantiated three times.
- FSM, operand registers and result capture stay in calc_sequencer.
- Bench models the adder behaviourally: add_s / add_cout = add_a + (add_sub ? ~add_b : add_b) + add_sub.

Test Plan (DEBOUNCE_CNT = 4):
1. A = 25, B = 17, op_sub = 0, press go -> result = 42, neg = 0, ovf = 0; result_valid high 2 cycles after go pulse; busy high for exactly 1 cycle.
2. A = 200, B = 100, add -> result = 44, ovf = 1. Then A = 100, B = 30, sub -> result = 70, neg = 0.
3. A = 30, B = 100, sub -> FIX visited (add_a = 100, add_b = 30); result = 70, neg = 1, valid 3 cycles after go. Then A = B = 55, sub -> result = 0, neg = 0.
4. After reset, load only A, press go -> state stays IDLE, result_valid = 0. Load B in SHOW -> result_valid drops next cycle.
5. Debounce:
   - btn_a high for 2 cycles -> no load.
   - Held 12 cycles with a 1-cycle dropout at cycle 3 -> exactly one load.
   - btn_go during EXEC -> ignored.
6. Assert rst while in FIX (A = 10, B = 20, sub) -> all outputs 0 and state IDLE immediately; a_ok / b_ok cleared, so a subsequent go is ignored.
